// File: rtl/tlc_monitor.sv
// tlc_monitor: passive watchdog on the four traffic-light buses.
// Decodes each one-hot light code, enforces safety / transition / timing /
// rotation rules, latches the first fault and reports the active direction.
module tlc_monitor #(
  parameter int GREEN_MIN  = 4,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 8,
  parameter int ALLRED_MAX = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       north_light,
  input  logic [2:0]       east_light,
  input  logic [2:0]       south_light,
  input  logic [2:0]       west_light,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             active_valid,
  output logic [1:0]       active_dir,
  output logic [CNT_W-1:0] phase_timer,
  output logic [15:0]      rotations
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    F_NONE           = 3'd0,
    F_ILLEGAL_CODE   = 3'd1,
    F_CONFLICT       = 3'd2,
    F_BAD_TRANSITION = 3'd3,
    F_SHORT_GREEN    = 3'd4,
    F_BAD_YELLOW     = 3'd5,
    F_ALLRED_TIMEOUT = 3'd6,
    F_BAD_ROTATION   = 3'd7
  } fault_e;

  // Index 0=N, 1=E, 2=S, 3=W throughout.
  logic [3:0][2:0] light_in;
  assign light_in = {west_light, south_light, east_light, north_light};

  logic [3:0][2:0]       code_q, code_d;
  logic [3:0][CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]      allred_q, allred_d;
  logic [1:0]            last_q, last_d;
  logic                  last_valid_q, last_valid_d;
  // Number of in-order greens (N,E,S,W) seen since the last rotation.
  logic [2:0]            rot_step_q, rot_step_d;
  logic                  fault_q, fault_d;
  fault_e                fault_code_q, fault_code_d;
  logic                  active_valid_q, active_valid_d;
  logic [1:0]            active_dir_q, active_dir_d;
  logic [CNT_W-1:0]      phase_timer_q, phase_timer_d;
  logic [15:0]           rotations_q, rotations_d;

  // Per-edge evaluation signals.
  logic [3:0]      legal;
  logic [3:0][2:0] eff;
  logic            any_illegal, all_red, conflict;
  logic            bad_trans, short_green, bad_yellow, allred_to, bad_rot;
  logic            green_start, west_end;
  logic [1:0]      green_dir, nonred_dir;
  logic [2:0]      nonred_cnt;
  fault_e          fault_now;

  // Rule checks, fault priority and next-state for all stored state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    code_d         = code_q;
    timer_d        = timer_q;
    allred_d       = allred_q;
    last_d         = last_q;
    last_valid_d   = last_valid_q;
    rot_step_d     = rot_step_q;
    fault_d        = fault_q;
    fault_code_d   = fault_code_q;
    rotations_d    = rotations_q;
    legal          = '0;
    eff            = code_q;
    any_illegal    = 1'b0;
    bad_trans      = 1'b0;
    short_green    = 1'b0;
    bad_yellow     = 1'b0;
    bad_rot        = 1'b0;
    green_start    = 1'b0;
    green_dir      = 2'd0;
    nonred_dir     = 2'd0;
    nonred_cnt     = 3'd0;
    fault_now      = F_NONE;

    for (int i = 0; i < 4; i++) begin
      legal[i] = $onehot(light_in[i]);
      // An illegal code is never taken as a colour: the stored one stands.
      eff[i]   = legal[i] ? light_in[i] : code_q[i];
      if (!legal[i]) any_illegal = 1'b1;
      if (eff[i] != RED) begin
        nonred_cnt = nonred_cnt + 3'd1;
        nonred_dir = 2'(i);
      end

      if (legal[i] && light_in[i] != code_q[i]) begin
        if (!((code_q[i] == RED && light_in[i] == GRN) ||
              (code_q[i] == GRN && light_in[i] == YEL) ||
              (code_q[i] == YEL && light_in[i] == RED)))
          bad_trans = 1'b1;
        if (code_q[i] == GRN && light_in[i] == YEL &&
            timer_q[i] < CNT_W'(GREEN_MIN))
          short_green = 1'b1;
        if (code_q[i] == YEL && light_in[i] == RED &&
            timer_q[i] < CNT_W'(YELLOW_MIN))
          bad_yellow = 1'b1;
        if (code_q[i] == RED && light_in[i] == GRN) begin
          green_start = 1'b1;
          green_dir   = 2'(i);
          if (last_valid_q && 2'(i) != last_q + 2'd1) bad_rot = 1'b1;
        end
        code_d[i]  = light_in[i];
        timer_d[i] = CNT_W'(1);
      end else begin
        if (code_q[i] == YEL && eff[i] == YEL && timer_q[i] == CNT_W'(YELLOW_MAX))
          bad_yellow = 1'b1;
        timer_d[i] = (timer_q[i] == CNT_MAX) ? CNT_MAX : timer_q[i] + CNT_W'(1);
      end
    end

    conflict  = (nonred_cnt >= 3'd2);
    all_red   = (nonred_cnt == 3'd0);
    allred_to = all_red && (allred_q == CNT_W'(ALLRED_MAX));
    allred_d  = !all_red ? '0 :
                (allred_q == CNT_MAX) ? CNT_MAX : allred_q + CNT_W'(1);

    if      (any_illegal) fault_now = F_ILLEGAL_CODE;
    else if (conflict)    fault_now = F_CONFLICT;
    else if (bad_trans)   fault_now = F_BAD_TRANSITION;
    else if (short_green) fault_now = F_SHORT_GREEN;
    else if (bad_yellow)  fault_now = F_BAD_YELLOW;
    else if (allred_to)   fault_now = F_ALLRED_TIMEOUT;
    else if (bad_rot)     fault_now = F_BAD_ROTATION;

    if (!fault_q && fault_now != F_NONE) begin
      fault_d      = 1'b1;
      fault_code_d = fault_now;
    end

    // A west yellow->red closes a rotation attempt, successful or not.
    west_end = legal[3] && code_q[3] == YEL && light_in[3] == RED;
    if (west_end) begin
      if (rot_step_q == 3'd4 && fault_now == F_NONE)
        rotations_d = rotations_q + 16'd1;
      rot_step_d = 3'd0;
    end

    if (green_start) begin
      last_d       = green_dir;
      last_valid_d = 1'b1;
      if ({1'b0, green_dir} == rot_step_q && !bad_rot)
        rot_step_d = rot_step_q + 3'd1;
      else if (green_dir == 2'd0)
        rot_step_d = 3'd1;
      else
        rot_step_d = 3'd0;
    end

    active_valid_d = !any_illegal && (nonred_cnt == 3'd1);
    active_dir_d   = active_valid_d ? nonred_dir : active_dir_q;
    phase_timer_d  = timer_d[active_dir_d];
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q         <= {4{RED}};
      timer_q        <= '0;
      allred_q       <= '0;
      last_q         <= 2'd0;
      last_valid_q   <= 1'b0;
      rot_step_q     <= 3'd0;
      fault_q        <= 1'b0;
      fault_code_q   <= F_NONE;
      active_valid_q <= 1'b0;
      active_dir_q   <= 2'd0;
      phase_timer_q  <= '0;
      rotations_q    <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      code_q         <= code_d;
      timer_q        <= timer_d;
      allred_q       <= allred_d;
      last_q         <= last_d;
      last_valid_q   <= last_valid_d;
      rot_step_q     <= rot_step_d;
      fault_q        <= fault_d;
      fault_code_q   <= fault_code_d;
      active_valid_q <= active_valid_d;
      active_dir_q   <= active_dir_d;
      phase_timer_q  <= phase_timer_d;
      rotations_q    <= rotations_d;
    end
  end

  assign fault        = fault_q;
  assign fault_code   = fault_code_q;
  assign active_valid = active_valid_q;
  assign active_dir   = active_dir_q;
  assign phase_timer  = phase_timer_q;
  assign rotations    = rotations_q;

endmodule

// File: tb/tb_tlc_monitor.sv
// Directed self-checking bench for tlc_monitor.
module tb_tlc_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0][2:0] lt;
  logic            fault;
  logic [2:0]      fault_code;
  logic            active_valid;
  logic [1:0]      active_dir;
  logic [7:0]      phase_timer;
  logic [15:0]     rotations;

  int n_tests = 0;
  int n_fail  = 0;

  tlc_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .north_light  (lt[0]),
    .east_light   (lt[1]),
    .south_light  (lt[2]),
    .west_light   (lt[3]),
    .fault        (fault),
    .fault_code   (fault_code),
    .active_valid (active_valid),
    .active_dir   (active_dir),
    .phase_timer  (phase_timer),
    .rotations    (rotations)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_fault"},      32'(fault),        32'd0);
    check({tag, "_fault_code"}, 32'(fault_code),   32'd0);
    check({tag, "_valid"},      32'(active_valid), 32'd0);
    check({tag, "_dir"},        32'(active_dir),   32'd0);
    check({tag, "_timer"},      32'(phase_timer),  32'd0);
    check({tag, "_rotations"},  32'(rotations),    32'd0);
  endtask

  // All directions red except d, which shows colour c.
  function automatic logic [3:0][2:0] one_dir(input int d, input logic [2:0] c);
    logic [3:0][2:0] v;
    v = {R, R, R, R};
    v[d] = c;
    return v;
  endfunction

  // Present v for n consecutive rising edges; return 1 time unit after the last.
  task automatic apply(input logic [3:0][2:0] v, input int n);
    repeat (n) begin
      lt = v;
      @(posedge clk);
      #1;
    end
  endtask

  // Assert reset now (asynchronous), release on the next falling edge.
  task automatic do_reset();
    rst = 1'b1;
    lt  = {R, R, R, R};
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0][2:0] v;
    rst = 1'b1;
    lt  = {R, R, R, R};
    #2;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // Legal rotation: each direction green 5, yellow 3, all red 2.
    for (int d = 0; d < 4; d++) begin
      apply(one_dir(d, G), 5);
      check($sformatf("rot%0d_g_valid", d), 32'(active_valid), 32'd1);
      check($sformatf("rot%0d_g_dir", d),   32'(active_dir),   32'(d));
      check($sformatf("rot%0d_g_timer", d), 32'(phase_timer),  32'd5);
      apply(one_dir(d, Y), 3);
      check($sformatf("rot%0d_y_timer", d), 32'(phase_timer),  32'd3);
      apply({R, R, R, R}, 2);
      check($sformatf("rot%0d_fault", d),   32'(fault),        32'd0);
      check($sformatf("rot%0d_valid_red", d), 32'(active_valid), 32'd0);
    end
    check("rot_count", 32'(rotations), 32'd1);

    // N and E green together: conflict, then an illegal south code stays masked.
    v = {R, R, G, G};
    apply(v, 1);
    check("conflict_fault", 32'(fault),      32'd1);
    check("conflict_code",  32'(fault_code), 32'd2);
    v = {R, 3'b011, G, G};
    apply(v, 1);
    check("sticky_code",    32'(fault_code), 32'd2);

    // Short green, then asynchronous reset mid-yellow.
    do_reset();
    check_reset("rst1");
    apply(one_dir(0, G), 3);
    check("short_pre_fault", 32'(fault), 32'd0);
    apply(one_dir(0, Y), 1);
    check("short_fault", 32'(fault),      32'd1);
    check("short_code",  32'(fault_code), 32'd4);
    apply(one_dir(0, Y), 1);
    check("midy_valid",  32'(active_valid), 32'd1);
    check("midy_timer",  32'(phase_timer),  32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    lt = {R, R, R, R};
    @(negedge clk);
    rst = 1'b0;

    // Yellow held 9 edges.
    apply(one_dir(0, G), 4);
    apply(one_dir(0, Y), 8);
    check("ylong_pre_fault", 32'(fault),       32'd0);
    check("ylong_pre_timer", 32'(phase_timer), 32'd8);
    apply(one_dir(0, Y), 1);
    check("ylong_code", 32'(fault_code), 32'd5);

    // Yellow held 1 edge then red.
    do_reset();
    apply(one_dir(0, G), 4);
    apply(one_dir(0, Y), 1);
    check("yshort_pre_fault", 32'(fault), 32'd0);
    apply({R, R, R, R}, 1);
    check("yshort_code", 32'(fault_code), 32'd5);

    // All red for 17 edges.
    do_reset();
    apply({R, R, R, R}, 16);
    check("allred16_fault", 32'(fault), 32'd0);
    apply({R, R, R, R}, 1);
    check("allred17_code", 32'(fault_code), 32'd6);

    // All red for 16 edges then N green: no fault.
    do_reset();
    apply({R, R, R, R}, 16);
    apply(one_dir(0, G), 1);
    check("allred16g_fault", 32'(fault),        32'd0);
    check("allred16g_valid", 32'(active_valid), 32'd1);
    check("allred16g_timer", 32'(phase_timer),  32'd1);

    // Legal N phase, then S green: bad rotation.
    do_reset();
    apply(one_dir(0, G), 4);
    apply(one_dir(0, Y), 2);
    apply({R, R, R, R}, 1);
    check("brot_pre_fault", 32'(fault), 32'd0);
    apply(one_dir(2, G), 1);
    check("brot_code", 32'(fault_code), 32'd7);
    check("brot_dir",  32'(active_dir), 32'd2);

    // Green straight to red: bad transition.
    do_reset();
    apply(one_dir(0, G), 4);
    apply({R, R, R, R}, 1);
    check("btrans_code", 32'(fault_code), 32'd3);

    // Illegal west code on the same edge as an N/E conflict: illegal wins.
    do_reset();
    v = {3'b000, R, G, G};
    apply(v, 1);
    check("prio_code",  32'(fault_code),   32'd1);
    check("prio_valid", 32'(active_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlc_monitor.md
# tlc_monitor

Passive checker on the receiving end of the `tlc` light buses. It samples `north_light`, `east_light`, `south_light` and `west_light` every clock and decodes each into red, yellow or green. It enforces safety, transition, timing and rotation rules, and reports the direction that currently holds the right of way. It sits beside `tlc` in the integration bench and in silicon as a watchdog; its latched fault output can force the intersection to flashing red.

## Interface
- `GREEN_MIN`, 4: minimum consecutive green cycles before yellow.
- `YELLOW_MIN`, 2: minimum consecutive yellow cycles.
- `YELLOW_MAX`, 8: maximum consecutive yellow cycles.
- `ALLRED_MAX`, 16: maximum consecutive cycles with all four directions red.
- `CNT_W`, 8: width of the duration counters. All counters saturate at 2^CNT_W-1.
- `clk`  input  1  single clock, shared with `tlc`; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `north_light`, `east_light`, `south_light`, `west_light`  input  3 each  one-hot light code: bit2=red, bit1=yellow, bit0=green.
- `fault`  output  1  sticky fault flag.
- `fault_code`  output  3  code of the first fault; 0 = none.
- `active_valid`  output  1  exactly one direction is non-red and every code is legal.
- `active_dir`  output  2  active direction: 0=N, 1=E, 2=S, 3=W. Holds its last value when `active_valid` is 0.
- `phase_timer`  output  CNT_W  cycles the active direction has held its current colour.
- `rotations`  output  16  completed N→E→S→W rotations; wraps modulo 2^16.

## Operation
- Stored state:
  - previous code per direction;
  - colour timer for each direction;
  - all-red timer;
  - last-green direction, plus a flag that it is valid.
- Each rising edge evaluates the current inputs against the stored state. Checks, in priority order (lowest code wins when several fire on the same edge):
  - 1 ILLEGAL_CODE: any input is not exactly one-hot (000, 011, 111, …).
  - 2 CONFLICT: two or more directions are non-red (yellow or green).
  - 3 BAD_TRANSITION: any direction changes other than red→green, green→yellow or yellow→red. Holding a colour is always legal.
  - 4 SHORT_GREEN: a green→yellow change when that direction's green count < GREEN_MIN.
  - 5 BAD_YELLOW: either of two conditions:
    - a yellow→red change with yellow count < YELLOW_MIN;
    - a yellow hold that would make the count YELLOW_MAX+1.
  - 6 ALLRED_TIMEOUT: an all-red sample that would make the all-red count ALLRED_MAX+1.
  - 7 BAD_ROTATION: a red→green change whose direction ≠ (last-green direction + 1) mod 4. The check applies only when last-green is valid; the first green after reset is accepted in any direction.
- Fault latching:
  - On the first fault, `fault`←1 and `fault_code`←code.
  - Later faults are ignored until reset.
  - Checking and the counters keep running after a fault.
- Colour timer:
  - Loads 1 on a colour change.
  - Increments on a hold.
- All-red timer:
  - Increments on each all-red sample.
  - Clears when any direction is non-red.
- `rotations` increments on a west yellow→red change, provided that west green's rotation check passed and the preceding greens after the last rotation were N, E and S in order.
- A `rotations` increment is suppressed if any fault fires on that same edge.
- Illegal codes are never stored as a colour; the previous colour is kept for that direction.

## Timing
- Outputs are registered. A violation present at the inputs before edge k shows on `fault`/`fault_code` after edge k (1-cycle latency).
- `active_valid`, `active_dir` and `phase_timer` reflect the inputs sampled at the most recent edge.
- Reset values (asynchronous, effective immediately, mid-operation included):
  - `fault`=0, `fault_code`=0;
  - `active_valid`=0, `active_dir`=0;
  - `phase_timer`=0, `rotations`=0;
  - stored codes all 3'b100;
  - all-red timer 0;
  - last-green invalid.
- First edge after reset release: all-red inputs count as all-red cycle 1.
- Durations count sampled edges.
  - A green held on edges k..k+3, then yellow at k+4, is a green count of 4.
  - With GREEN_MIN=4 this passes; a count of 3 faults.
- Counter saturation at 2^CNT_W-1 never wraps and never causes a fault by itself.

## Test plan
- Reset release, then a legal rotation: N green 5 cycles, yellow 3, all red 2, then E, S and W the same way.
  - `fault`=0 throughout.
  - `rotations`=1 after W yellow→red.
  - `active_dir` steps 0,1,2,3.
- N green and E green together, from a legal state: `fault`=1 and `fault_code`=2 one edge later.
  - The test then also drives `south_light`=3'b011 on a later edge; `fault_code` must stay 2 (sticky).
- Hold N green for 3 cycles, then yellow: `fault_code`=4. Then reset mid-yellow: all outputs return to their reset values immediately, without waiting for an edge.
- Yellow held 9 cycles: `fault_code`=5 on the 9th edge.
  - Separately: yellow held 1 cycle, then red → `fault_code`=5.
- All red for 17 consecutive edges after reset: `fault_code`=6 on edge 17. With 16 edges followed by N green, there is no fault.
- Legal N phase, then S green: `fault_code`=7.
  - Separately: green→red directly → `fault_code`=3.
  - Separately: west=3'b000 on the same edge as an N/E conflict → `fault_code`=1 (priority).
